// File: rtl/pi_controller_mc.sv
// pi_controller_mc: time-shared multi-channel PI controller for the FOC loop.
// One datapath serves CH channels (e.g. Id and Iq). Each channel owns its own
// Kp/Ki gains and integrator. A symmetric output limit +/-L clamps both the
// integrator (anti-windup) and the final sum.
// Pipeline: S1 error -> S2 gain products -> S3 integrator RMW -> S4 sum -> output.
// Optional macro PI_ROUND_EN: round-half-up on the final shift instead of floor.
module pi_controller_mc #(
    parameter int DW      = 16,
    parameter int CH      = 2,
    parameter int GW      = 24,
    parameter int FRAC    = 16,
    parameter int ACCW    = 32,
    parameter int KP_INIT = 32768,
    parameter int KI_INIT = 2,
    localparam int CHW    = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            i_en,
    input  logic [CHW-1:0]  i_ch,
    input  logic [DW-1:0]   i_aim,
    input  logic [DW-1:0]   i_real,
    input  logic            i_cfg_we,
    input  logic [CHW-1:0]  i_cfg_ch,
    input  logic [GW-1:0]   i_cfg_kp,
    input  logic [GW-1:0]   i_cfg_ki,
    input  logic [DW-2:0]   i_lim,
    input  logic            i_clr,
    output logic            o_en,
    output logic [CHW-1:0]  o_ch,
    output logic [DW-1:0]   o_value
);

    // Width of the raw error*gain product (signed error, gain with a zero sign bit).
    localparam int PW = DW + GW + 2;
    localparam logic signed [PW-1:0] PMAX = {{(PW-ACCW+1){1'b0}}, {(ACCW-1){1'b1}}};
    localparam logic signed [PW-1:0] PMIN = -PMAX;
`ifdef PI_ROUND_EN
    localparam logic signed [ACCW:0] HALF = {{(ACCW+1-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
`endif

    // Saturate a full product to +/-(2^(ACCW-1)-1).
    function automatic logic signed [ACCW-1:0] sat_acc(input logic signed [PW-1:0] x);
        if (x > PMAX) return PMAX[ACCW-1:0];
        if (x < PMIN) return PMIN[ACCW-1:0];
        return x[ACCW-1:0];
    endfunction

    // Clamp a one-bit-wider value into the symmetric window [-b, +b].
    function automatic logic signed [ACCW-1:0] clamp_b(input logic signed [ACCW:0] x,
                                                        input logic signed [ACCW:0] b);
        logic signed [ACCW:0] nb;
        nb = -b;
        if (x > b)  return b[ACCW-1:0];
        if (x < nb) return nb[ACCW-1:0];
        return x[ACCW-1:0];
    endfunction

`ifdef PI_ROUND_EN
    // Round half up, drop the fraction, then re-clamp to +/-L.
    function automatic logic signed [DW-1:0] scale_out(input logic signed [ACCW-1:0] s,
                                                        input logic [DW-2:0] lim);
        logic signed [ACCW:0] x;
        logic signed [ACCW:0] l;
        x = {s[ACCW-1], s};
        x = x + HALF;
        x = x >>> FRAC;
        l = {{(ACCW+2-DW){1'b0}}, lim};
        if (x > l)       x = l;
        else if (x < -l) x = -l;
        return x[DW-1:0];
    endfunction
`else
    // Drop the fraction with an arithmetic shift (floor).
    function automatic logic signed [DW-1:0] scale_out(input logic signed [ACCW-1:0] s);
        logic signed [ACCW-1:0] x;
        x = s >>> FRAC;
        return x[DW-1:0];
    endfunction
`endif

    logic [GW-1:0]            kp_q [CH];
    logic [GW-1:0]            ki_q [CH];
    logic signed [ACCW-1:0]   integ_q [CH];

    logic                     ch_ok;
    logic [GW-1:0]            kp_eff;
    logic [GW-1:0]            ki_eff;
    logic signed [PW-1:0]     p_full;
    logic signed [PW-1:0]     i_full;
    logic signed [ACCW:0]     bound;
    logic signed [ACCW-1:0]   integ_cur;
    logic signed [ACCW:0]     integ_sum;
    logic signed [ACCW-1:0]   integ_new;
    logic signed [ACCW:0]     sum_full;

    logic                     vld_p0, vld_p1, vld_p2, vld_p3;
    logic signed [DW:0]       err_p0;
    logic [CHW-1:0]           ch_p0, ch_p1, ch_p2, ch_p3;
    logic signed [ACCW-1:0]   p_p1, iinc_p1;
    logic signed [ACCW-1:0]   p_p2, integ_p2;
    logic signed [ACCW-1:0]   sum_p3;

    // Flag samples whose channel index names a real channel; others are dropped.
    always_comb begin
        ch_ok = 1'b0;
        for (int c = 0; c < CH; c++) begin
            if (i_ch == CHW'(c)) ch_ok = 1'b1;
        end
    end

    // S2 gain selection with forwarding of a write landing on the same edge,
    // then error*gain products; S3 integrator read-modify-write; S4 sum.
    always_comb begin
        kp_eff = kp_q[ch_p0];
        ki_eff = ki_q[ch_p0];
        if (i_cfg_we && (i_cfg_ch == ch_p0)) begin
            kp_eff = i_cfg_kp;
            ki_eff = i_cfg_ki;
        end
        p_full = {{(PW-DW-1){err_p0[DW]}}, err_p0} * {{(PW-GW){1'b0}}, kp_eff};
        i_full = {{(PW-DW-1){err_p0[DW]}}, err_p0} * {{(PW-GW){1'b0}}, ki_eff};

        bound     = {{(ACCW-DW-FRAC+2){1'b0}}, i_lim, {FRAC{1'b0}}};
        integ_cur = integ_q[ch_p1];
        integ_sum = {integ_cur[ACCW-1], integ_cur} + {iinc_p1[ACCW-1], iinc_p1};
        integ_new = clamp_b(integ_sum, bound);

        sum_full  = {p_p2[ACCW-1], p_p2} + {integ_p2[ACCW-1], integ_p2};
    end

    // Per-channel gain registers; writes to nonexistent channels match nothing.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int c = 0; c < CH; c++) begin
                kp_q[c] <= GW'(KP_INIT);
                ki_q[c] <= GW'(KI_INIT);
            end
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (i_cfg_we && (i_cfg_ch == CHW'(c))) begin
                    kp_q[c] <= i_cfg_kp;
                    ki_q[c] <= i_cfg_ki;
                end
            end
        end
    end

    // Integrators: global clear beats a coincident S3 update.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int c = 0; c < CH; c++) integ_q[c] <= '0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (i_clr)
                    integ_q[c] <= '0;
                else if (vld_p1 && (ch_p1 == CHW'(c)))
                    integ_q[c] <= integ_new;
            end
        end
    end

    // Datapath pipeline registers; they carry no reset, validity comes from vld_pN.
    always_ff @(posedge clk) begin
        // S1: error at DW+1 bits, channel latched
        err_p0   <= {i_aim[DW-1], i_aim} - {i_real[DW-1], i_real};
        ch_p0    <= i_ch;
        // S2: saturated proportional term and integrator increment
        p_p1     <= sat_acc(p_full);
        iinc_p1  <= sat_acc(i_full);
        ch_p1    <= ch_p0;
        // S3: clamped integrator value travels with P
        p_p2     <= p_p1;
        integ_p2 <= integ_new;
        ch_p2    <= ch_p1;
        // S4: clamped saturating sum
        sum_p3   <= clamp_b(sum_full, bound);
        ch_p3    <= ch_p2;
    end

    // Valid chain and output registers; outputs hold while no result is presented.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            vld_p3  <= 1'b0;
            o_en    <= 1'b0;
            o_ch    <= '0;
            o_value <= '0;
        end else begin
            vld_p0 <= i_en && ch_ok;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
            vld_p3 <= vld_p2;
            o_en   <= vld_p3;
            if (vld_p3) begin
                o_ch <= ch_p3;
`ifdef PI_ROUND_EN
                o_value <= scale_out(sum_p3, i_lim);
`else
                o_value <= scale_out(sum_p3);
`endif
            end
        end
    end

endmodule

// File: tb/tb_pi_controller_mc.sv
// Scoreboard bench for pi_controller_mc: stimulus pushes hand-computed expected
// results into a queue, a negedge monitor pops and compares whenever o_en is high.
module tb_pi_controller_mc;

    logic        clk = 1'b0;
    logic        rstn;
    logic        i_en;
    logic [0:0]  i_ch;
    logic [15:0] i_aim;
    logic [15:0] i_real;
    logic        i_cfg_we;
    logic [0:0]  i_cfg_ch;
    logic [23:0] i_cfg_kp;
    logic [23:0] i_cfg_ki;
    logic [14:0] i_lim;
    logic        i_clr;
    logic        o_en;
    logic [0:0]  o_ch;
    logic [15:0] o_value;

    pi_controller_mc dut (
        .clk      (clk),
        .rstn     (rstn),
        .i_en     (i_en),
        .i_ch     (i_ch),
        .i_aim    (i_aim),
        .i_real   (i_real),
        .i_cfg_we (i_cfg_we),
        .i_cfg_ch (i_cfg_ch),
        .i_cfg_kp (i_cfg_kp),
        .i_cfg_ki (i_cfg_ki),
        .i_lim    (i_lim),
        .i_clr    (i_clr),
        .o_en     (o_en),
        .o_ch     (o_ch),
        .o_value  (o_value)
    );

    always #5 clk = ~clk;

`ifdef PI_ROUND_EN
    localparam int R_POS = 2;   // 1.50009 rounds to 2
    localparam int R_HALF_POS = 2;   // exactly 1.5 -> 2
    localparam int R_HALF_NEG = -1;  // exactly -1.5 -> -1
`else
    localparam int R_POS = 1;
    localparam int R_HALF_POS = 1;
    localparam int R_HALF_NEG = -2;
`endif

    typedef struct {
        int id;
        int val;
        int ch;
        bit chk;
        int edge_no;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   next_id = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int id, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s #%0d: got %0d, required %0d", name, id, act, req);
        end
    endtask

    // Monitor: every presented result must match the oldest expectation.
    always @(negedge clk) begin
        if (rstn && o_en) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_o_en: got o_en=1 ch=%0d value=%0d, required no output",
                         o_ch, $signed(o_value));
            end else begin
                exp_t e;
                e = q.pop_front();
                check("latency_edge", e.id, cyc, e.edge_no + 4);
                check("o_ch", e.id, int'(o_ch), e.ch);
                if (e.chk) check("o_value", e.id, int'($signed(o_value)), e.val);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        i_en     = 1'b0;
        i_cfg_we = 1'b0;
        i_clr    = 1'b0;
    endtask

    task automatic issue(input int ch, input int aim, input int rl, input int expv, input bit chk);
        exp_t e;
        i_en   = 1'b1;
        i_ch   = 1'(ch);
        i_aim  = 16'(aim);
        i_real = 16'(rl);
        e.id = next_id;
        e.val = expv;
        e.ch = ch;
        e.chk = chk;
        e.edge_no = cyc + 1;
        next_id++;
        q.push_back(e);
        tick();
    endtask

    task automatic cfg(input int ch, input int kp, input int ki);
        i_cfg_we = 1'b1;
        i_cfg_ch = 1'(ch);
        i_cfg_kp = 24'(kp);
        i_cfg_ki = 24'(ki);
        tick();
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && q.size() != 0; i++) tick();
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending results, required 0", q.size());
            q.delete();
        end
        tick();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish by time limit, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; i_en = 1'b0; i_ch = '0; i_aim = '0; i_real = '0;
        i_cfg_we = 1'b0; i_cfg_ch = '0; i_cfg_kp = '0; i_cfg_ki = '0;
        i_lim = 15'd32767; i_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_o_en", -1, int'(o_en), 0);
        check("reset_o_ch", -1, int'(o_ch), 0);
        check("reset_o_value", -1, int'($signed(o_value)), 0);
        rstn = 1'b1;
        tick();

        // Proportional only, including saturation at both extremes.
        cfg(0, 65536, 0);
        issue(0, 1000, 0, 1000, 1);
        issue(0, -200, 300, -500, 1);
        issue(0, 32767, -32768, 32767, 1);
        issue(0, -32768, 32767, -32767, 1);
        drain();

        // Integrator with anti-windup at L=500.
        cfg(0, 0, 65536);
        i_lim = 15'd500;
        tick();
        for (int k = 1; k <= 7; k++) issue(0, 100, 0, (k < 5) ? k * 100 : 500, 1);
        issue(0, 0, 100, 400, 1);
        drain();

        // Channel isolation, interleaved back-to-back.
        cfg(1, 0, 65536);
        for (int k = 1; k <= 3; k++) begin
            issue(0, 100, 0, 500, 1);
            issue(1, 0, 50, -50 * k, 1);
        end
        drain();

        // Clear coincident with a ch0 sample in S3: sample still emerges, clear wins.
        issue(0, 100, 0, 0, 0);
        tick();
        i_clr = 1'b1;
        tick();
        drain();
        issue(0, 100, 0, 100, 1);
        issue(1, 0, 50, -50, 1);
        drain();

        // Gain write one cycle after the sample: new Kp=2.0, Ki=0 applies (old gains give 10).
        i_clr = 1'b1;
        tick();
        issue(0, 10, 0, 20, 1);
        cfg(0, 131072, 0);
        drain();

        // L=0 forces zero output and holds the integrator at zero.
        cfg(0, 65536, 65536);
        i_lim = 15'd0;
        tick();
        issue(0, 100, 0, 0, 1);
        drain();
        i_lim = 15'd32767;
        cfg(0, 0, 65536);
        issue(0, 0, 0, 0, 1);
        drain();

        // Exact half-LSB results: +1.5 and -1.5.
        cfg(1, 32768, 0);
        issue(1, 3, 0, R_HALF_POS, 1);
        issue(1, 0, 3, R_HALF_NEG, 1);
        drain();

        // Reset with three samples in flight.
        issue(0, 1000, 0, 0, 0);
        issue(0, 1000, 0, 0, 0);
        issue(1, 1000, 0, 0, 0);
        rstn = 1'b0;
        q.delete();
        tick();
        tick();
        check("midreset_o_en", -1, int'(o_en), 0);
        check("midreset_o_value", -1, int'($signed(o_value)), 0);
        rstn = 1'b1;
        repeat (8) tick();
        check("postreset_o_en", -1, int'(o_en), 0);
        check("postreset_o_value", -1, int'($signed(o_value)), 0);

        // Gains back to Kp=0.5, Ki=2/65536: err=3 -> 98310/65536, err=-3 -> -98310/65536.
        issue(0, 3, 0, R_POS, 1);
        issue(1, 0, 3, -2, 1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
